// File: rtl/pipe_pkg.sv
// Shared types and encodings for the ID-stage hazard/forwarding unit.
// Shadow entries mirror the destination side of in-flight instructions.
package pipe_pkg;

  localparam logic [2:0] FWD_RF  = 3'd0;
  localparam logic [2:0] FWD_EX  = 3'd1;
  localparam logic [2:0] FWD_MEM = 3'd2;
  localparam logic [2:0] FWD_WB  = 3'd3;

  localparam int REG_ZERO = 0;
  localparam int SH_AW    = 8;

  typedef struct packed {
    logic             valid;
    logic [SH_AW-1:0] waddr;
    logic             wena;
    logic             is_load;
  } shadow_t;

endpackage

// File: rtl/pipe_fwd_mux.sv
// Priority operand match over the shadow pipeline for one source operand.
// Youngest matching stage wins; a young load raises a hazard instead.
module pipe_fwd_mux
  import pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1
) (
  input  shadow_t [FWD_DEPTH-1:0]   ent_i,
  input  logic [AW-1:0]             addr_i,
  input  logic                      rena_i,
  input  logic [XLEN-1:0]           rf_data_i,
  input  logic [FWD_DEPTH*XLEN-1:0] stage_data_i,
  output logic [2:0]                sel_o,
  output logic [XLEN-1:0]           data_o,
  output logic                      hazard_o
);

  logic [SH_AW-1:0] addr_x;
  logic             addr_nz;

  assign addr_x  = SH_AW'(addr_i);
  assign addr_nz = (addr_x != SH_AW'(REG_ZERO));

  // Walk oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel_o    = FWD_RF;
    data_o   = rf_data_i;
    hazard_o = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (ent_i[k].valid && ent_i[k].wena &&
          ent_i[k].waddr == addr_x &&
          addr_nz && rena_i) begin
        sel_o    = 3'(k + 1);
        data_o   = stage_data_i[k*XLEN +: XLEN];
        hazard_o = ent_i[k].is_load &&
                   ((k + 1) <= LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/pipe_id_hazard.sv
// ID-stage hazard unit: shadow destination pipeline, operand
// forwarding, load-use stall and saturating performance counters.
module pipe_id_hazard
  import pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 32
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_id_valid,
  input  logic [AW-1:0]             in_rs_addr,
  input  logic [AW-1:0]             in_rt_addr,
  input  logic                      in_rs_rena,
  input  logic                      in_rt_rena,
  input  logic [AW-1:0]             in_rd_addr,
  input  logic                      in_rd_wena,
  input  logic                      in_is_load,
  input  logic                      in_flush,
  input  logic [XLEN-1:0]           in_rf_rs_data,
  input  logic [XLEN-1:0]           in_rf_rt_data,
  input  logic [FWD_DEPTH*XLEN-1:0] in_stage_data,
  output logic [XLEN-1:0]           out_rs_data,
  output logic [XLEN-1:0]           out_rt_data,
  output logic [2:0]                out_rs_fwd_sel,
  output logic [2:0]                out_rt_fwd_sel,
  output logic                      out_stall,
  output logic [CNT_W-1:0]          out_stall_cycles,
  output logic [CNT_W-1:0]          out_fwd_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  shadow_t [FWD_DEPTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] fwd_q, fwd_d;
  logic haz_a, haz_b;
  logic issue, fwd_any;

  pipe_fwd_mux #(
    .XLEN(XLEN), .AW(AW),
    .FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT)
  ) u_mux_a (
    .ent_i(sh_q), .addr_i(in_rs_addr),
    .rena_i(in_rs_rena), .rf_data_i(in_rf_rs_data),
    .stage_data_i(in_stage_data),
    .sel_o(out_rs_fwd_sel), .data_o(out_rs_data),
    .hazard_o(haz_a)
  );

  pipe_fwd_mux #(
    .XLEN(XLEN), .AW(AW),
    .FWD_DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT)
  ) u_mux_b (
    .ent_i(sh_q), .addr_i(in_rt_addr),
    .rena_i(in_rt_rena), .rf_data_i(in_rf_rt_data),
    .stage_data_i(in_stage_data),
    .sel_o(out_rt_fwd_sel), .data_o(out_rt_data),
    .hazard_o(haz_b)
  );

  // Flush dominates a hazard: the squashed instruction needs no data.
  assign out_stall = in_id_valid & ~in_flush & (haz_a | haz_b);
  assign issue     = in_id_valid & ~out_stall & ~in_flush;
  assign fwd_any   = (out_rs_fwd_sel != FWD_RF) |
                     (out_rt_fwd_sel != FWD_RF);

  always_comb begin
    sh_d = '0;
    for (int k = 1; k < FWD_DEPTH; k++) begin
      sh_d[k] = sh_q[k-1];
    end
    if (issue) begin
      sh_d[0].valid   = 1'b1;
      sh_d[0].waddr   = SH_AW'(in_rd_addr);
      sh_d[0].wena    = in_rd_wena;
      sh_d[0].is_load = in_is_load;
    end
  end

  always_comb begin
    stall_d = stall_q;
    fwd_d   = fwd_q;
    if (out_stall && stall_q != CNT_MAX) begin
      stall_d = stall_q + 1'b1;
    end
    if (fwd_any && in_id_valid && !out_stall &&
        fwd_q != CNT_MAX) begin
      fwd_d = fwd_q + 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      sh_q    <= '0;
      stall_q <= '0;
      fwd_q   <= '0;
    end else begin
      sh_q    <= sh_d;
      stall_q <= stall_d;
      fwd_q   <= fwd_d;
    end
  end

  assign out_stall_cycles = stall_q;
  assign out_fwd_count    = fwd_q;

endmodule

// File: doc/pipe_id_hazard.md
Name: pipe_id_hazard

Overview:
- Parametrised hazard/forwarding unit for the ID stage. It replaces the stall-only interlock with a tracked in-flight destination shadow pipeline.
- Forwards operands from any of FWD_DEPTH downstream stages and stalls only on load-use hazards.
- Provides forwarded operands to branch compare and the ID/EX register.
- Keeps saturating stall/forward performance counters.

Parameters:
XLEN, 32, datapath width
AW, 5, register address width; address 0 is hardwired zero
FWD_DEPTH, 3, tracked downstream stages (1=EX, 2=MEM, 3=WB), range 1..4
LOAD_LAT, 1, a load in stage k<=LOAD_LAT has no data yet
CNT_W, 32, performance counter width

Ports:
in_clk  in  1  clock, rising edge
in_rst  in  1  synchronous reset, active-low
in_id_valid  in  1  ID holds a real instruction
in_rs_addr  in  AW  source A address
in_rt_addr  in  AW  source B address
in_rs_rena  in  1  source A is read
in_rt_rena  in  1  source B is read
in_rd_addr  in  AW  destination of ID instruction
in_rd_wena  in  1  ID instruction writes a register
in_is_load  in  1  ID instruction is a load
in_flush  in  1  squash ID instruction (taken branch/jump)
in_rf_rs_data  in  XLEN  regfile read A
in_rf_rt_data  in  XLEN  regfile read B
in_stage_data  in  FWD_DEPTH*XLEN  result of stage k in slice k-1
out_rs_data  out  XLEN  forwarded operand A
out_rt_data  out  XLEN  forwarded operand B
out_rs_fwd_sel  out  3  0=regfile, k=stage k
out_rt_fwd_sel  out  3  same encoding for B
out_stall  out  1  hold PC and IF/ID; insert bubble into EX
out_stall_cycles  out  CNT_W  saturating count of stall cycles
out_fwd_count  out  CNT_W  saturating count of cycles where any operand was forwarded

Behaviour:
- Shadow pipeline: FWD_DEPTH entries, each holding {valid, waddr, wena, is_load}. Entry 1 is EX.
- Each rising edge: entry k+1 <= entry k. Entry 1 <= ID instruction if in_id_valid & !out_stall & !in_flush; otherwise it receives a bubble (valid=0).
- Match for entry k on an operand: valid & wena & waddr==addr & addr!=0 & rena.
- Priority: the lowest k (youngest) match wins. Older matches are ignored.
- Winning match at k with is_load and k<=LOAD_LAT: hazard. Otherwise fwd_sel=k and the operand comes from slice k-1.
- No match: fwd_sel=0 and the operand comes from the regfile input.
- out_stall = in_id_valid & !in_flush & (hazard on A | hazard on B). It is combinational with zero latency.
- Flush and hazard together: flush wins. out_stall=0 and a bubble is inserted.
- During a stall, entry 1 receives a bubble each cycle, so the hazard clears after LOAD_LAT-k+1 cycles. No deadlock is possible.
- While out_stall=1, out_*_data and out_*_fwd_sel still show the non-hazard choice. They are don't-care for the consumer.
- Counters:
  - out_stall_cycles increments on each edge where out_stall=1.
  - out_fwd_count increments where (sel_A!=0 | sel_B!=0) & in_id_valid & !out_stall.
  - Both saturate at all-ones. They do not wrap.
- Reset (in_rst==0 at an edge): all entries invalid and both counters 0. Consequently out_stall=0 and fwd_sel=0 in the first cycle after reset.
- Reset asserted mid-stall drops the stall the next cycle; the pending load is forgotten.
- Register 0 is never forwarded and never stalls.
- FWD_DEPTH=1: only EX is tracked. The unit is then still correct only if the regfile is write-before-read for older results; this is the integrator's requirement.

Decomposition:
- Shared package pipe_pkg:
  - fwd_sel encoding constants: FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3.
  - REG_ZERO constant.
  - Shadow-entry struct typedef.
- Sub-module pipe_fwd_mux, instantiated once per operand. It performs the priority match over the entries and produces {sel, data, hazard}.
- Top level holds the shadow pipeline, stall logic and counters.

Test Plan:
- add r3 in EX, then ID reads rs=r3, EX data=0x1234 -> out_rs_fwd_sel=1, out_rs_data=0x1234, out_stall=0, fwd_count +1.
- lw r5 in EX (LOAD_LAT=1), ID reads rt=r5:
  - First cycle: out_stall=1.
  - Next cycle (load now in MEM): stall=0, out_rt_fwd_sel=2, data=MEM slice, stall_cycles=1.
- r7 written by both EX (0xA) and MEM (0xB), ID reads r7 -> sel=1, data=0xA (youngest wins).
- ID reads r0 while EX writes r0 with data 0xFFFF -> sel=0, data=in_rf_rs_data, no stall.
- Load-use hazard with in_flush=1 in the same cycle -> out_stall=0, and EX entry is a bubble next cycle.
- Assert in_rst=0 during a stall, release it, then preload stall_cycles to all-ones via force and stall once:
  - After reset: out_stall=0 and counters=0.
  - Counter held at all-ones after the stall.
